// File: rtl/robo_pkg.sv
// Shared types for the pipe-inspection robot navigation controller.
// States, orientation codes and debris lives used by controller and bench.
package robo_pkg;

    typedef enum logic [2:0] {
        INICIO      = 3'd0,
        SEGUINDO    = 3'd1,
        VIROU_ESQ   = 3'd2,
        GIRANDO_DIR = 3'd3,
        REMOVENDO   = 3'd4,
        FIM         = 3'd5,
        ERRO        = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ORI_N = 2'b00,
        ORI_S = 2'b01,
        ORI_L = 2'b10,
        ORI_O = 2'b11
    } orient_t;

    localparam int DEF_MAX_REMOCAO = 12;
    localparam int DEF_MAX_GIROS   = 8;

    localparam logic [2:0] DEB_LEVE  = 3'd3;
    localparam logic [2:0] DEB_MEDIO = 3'd4;
    localparam logic [2:0] DEB_PESADO = 3'd5;

    // Remover steps needed to clear each debris code in the map.
    function automatic int vidas_detrito(input logic [2:0] codigo);
        int v;
        v = 0;
        case (codigo)
            DEB_LEVE:   v = 3;
            DEB_MEDIO:  v = 6;
            DEB_PESADO: v = 9;
            default:    v = 0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/contador_sat.sv
// Saturating up-counter with clear and enable.
// clr restarts the count; with en also high the restart counts this step.
module contador_sat #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= en ? W'(1) : '0;
        end else if (en && (q != W'(MAX))) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/robo_controle_parede.sv
// Left-hand wall-following navigation controller: one command per passo,
// debris removal with timeout, end-of-pipe and spin-lock detection.
module robo_controle_parede
    import robo_pkg::*;
#(
    parameter int MAX_REMOCAO = DEF_MAX_REMOCAO,
    parameter int MAX_GIROS   = DEF_MAX_GIROS
) (
    input  logic clock,
    input  logic reset,
    input  logic passo,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic avancar,
    output logic girar,
    output logic remover,
    output logic fim,
    output logic erro
);

    localparam int RW = $clog2(MAX_REMOCAO + 1);
    localparam int GW = $clog2(MAX_GIROS + 1);

    state_t          state;
    state_t          nstate;
    state_t          alvo_giro;
    logic            saiu;
    logic [1:0]      cnt_dir;
    logic [1:0]      dir_nxt;
    logic [RW-1:0]   cnt_rem;
    logic [GW-1:0]   cnt_giro;
    logic            cmd_av;
    logic            cmd_gi;
    logic            cmd_re;
    logic            pede_giro;
    logic            giro_clr;
    logic            giro_en;
    logic            rem_clr;
    logic            rem_en;
    logic            giro_cheio;
    logic            rem_cheio;
    logic            terminal;

    contador_sat #(.MAX(MAX_GIROS), .W(GW)) u_cnt_giro (
        .clock (clock),
        .reset (reset),
        .clr   (giro_clr),
        .en    (giro_en),
        .q     (cnt_giro)
    );

    contador_sat #(.MAX(MAX_REMOCAO), .W(RW)) u_cnt_rem (
        .clock (clock),
        .reset (reset),
        .clr   (rem_clr),
        .en    (rem_en),
        .q     (cnt_rem)
    );

    assign terminal   = (state == FIM) || (state == ERRO);
    // One more girar would reach the spin limit.
    assign giro_cheio = (cnt_giro >= GW'(MAX_GIROS - 1));
    assign rem_cheio  = (cnt_rem >= RW'(MAX_REMOCAO));

    always_comb begin
        nstate    = state;
        alvo_giro = state;
        dir_nxt   = cnt_dir;
        pede_giro = 1'b0;
        cmd_av    = 1'b0;
        cmd_gi    = 1'b0;
        cmd_re    = 1'b0;
        giro_clr  = 1'b0;
        giro_en   = 1'b0;
        rem_clr   = 1'b0;
        rem_en    = 1'b0;
        if (passo) begin
            unique case (state)
                INICIO, SEGUINDO, VIROU_ESQ: begin
                    if (under && saiu) begin
                        nstate = FIM;
                    end else if (barrier) begin
                        cmd_re  = 1'b1;
                        rem_clr = 1'b1;
                        rem_en  = 1'b1;
                        nstate  = REMOVENDO;
                    end else if (!left && (state != VIROU_ESQ)) begin
                        pede_giro = 1'b1;
                        alvo_giro = VIROU_ESQ;
                    end else if (!head) begin
                        cmd_av   = 1'b1;
                        giro_clr = 1'b1;
                        nstate   = SEGUINDO;
                    end else begin
                        pede_giro = 1'b1;
                        alvo_giro = GIRANDO_DIR;
                        dir_nxt   = 2'd1;
                    end
                end
                GIRANDO_DIR: begin
                    // Three left turns make one net right turn.
                    pede_giro = 1'b1;
                    dir_nxt   = cnt_dir + 2'd1;
                    alvo_giro = (cnt_dir == 2'd2) ? SEGUINDO : GIRANDO_DIR;
                end
                REMOVENDO: begin
                    if (barrier) begin
                        if (rem_cheio) begin
                            nstate = ERRO;
                        end else begin
                            cmd_re = 1'b1;
                            rem_en = 1'b1;
                        end
                    end else begin
                        cmd_av   = 1'b1;
                        rem_clr  = 1'b1;
                        giro_clr = 1'b1;
                        nstate   = SEGUINDO;
                    end
                end
                FIM, ERRO: begin
                end
                default: begin
                    nstate = ERRO;
                end
            endcase
            if (pede_giro) begin
                if (giro_cheio) begin
                    nstate = ERRO;
                end else begin
                    cmd_gi  = 1'b1;
                    giro_en = 1'b1;
                    nstate  = alvo_giro;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= INICIO;
            saiu    <= 1'b0;
            cnt_dir <= 2'd0;
            avancar <= 1'b0;
            girar   <= 1'b0;
            remover <= 1'b0;
        end else begin
            state   <= nstate;
            cnt_dir <= dir_nxt;
            saiu    <= saiu | (passo & ~under & ~terminal);
            avancar <= cmd_av;
            girar   <= cmd_gi;
            remover <= cmd_re;
        end
    end

    assign fim  = (state == FIM);
    assign erro = (state == ERRO);

endmodule

// File: tb/tb_robo_controle_parede.sv
// Self-checking bench: directed scenarios plus random sensor streams
// compared against a step-level behavioural model of the controller.
module tb_robo_controle_parede;
    import robo_pkg::*;

    localparam int MAX_REM  = 12;
    localparam int MAX_GIRO = 8;

    logic clock = 1'b0;
    logic reset;
    logic passo;
    logic head;
    logic left;
    logic under;
    logic barrier;
    logic avancar;
    logic girar;
    logic remover;
    logic fim;
    logic erro;

    int checks   = 0;
    int failures = 0;

    // Model: what the robot is doing, in plain terms.
    bit       m_fim;
    bit       m_err;
    bit       m_saiu;
    bit       m_just_left;
    bit       m_removing;
    int       m_right_left;
    int       m_spins;
    int       m_hits;
    logic [2:0] exp_cmd;

    always #5 clock = ~clock;

    robo_controle_parede #(
        .MAX_REMOCAO (MAX_REM),
        .MAX_GIROS   (MAX_GIRO)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .passo   (passo),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .avancar (avancar),
        .girar   (girar),
        .remover (remover),
        .fim     (fim),
        .erro    (erro)
    );

    task automatic model_reset();
        m_fim        = 0;
        m_err        = 0;
        m_saiu       = 0;
        m_just_left  = 0;
        m_removing   = 0;
        m_right_left = 0;
        m_spins      = 0;
        m_hits       = 0;
        exp_cmd      = 3'b000;
    endtask

    task automatic model_turn();
        if (m_spins + 1 >= MAX_GIRO) begin
            m_err = 1;
        end else begin
            m_spins++;
            exp_cmd = 3'b010;
        end
    endtask

    task automatic model_step(input bit h, input bit l, input bit u, input bit b);
        exp_cmd = 3'b000;
        if (m_fim || m_err) return;
        if (!u) m_saiu = 1;
        if (m_right_left > 0) begin
            m_right_left--;
            model_turn();
        end else if (m_removing) begin
            if (b) begin
                if (m_hits == MAX_REM) begin
                    m_err = 1;
                end else begin
                    m_hits++;
                    exp_cmd = 3'b001;
                end
            end else begin
                m_removing = 0;
                m_hits     = 0;
                m_spins    = 0;
                exp_cmd    = 3'b100;
            end
        end else if (u && m_saiu) begin
            m_fim = 1;
        end else if (b) begin
            m_removing  = 1;
            m_hits      = 1;
            m_just_left = 0;
            exp_cmd     = 3'b001;
        end else if (!l && !m_just_left) begin
            model_turn();
            m_just_left = 1;
        end else if (!h) begin
            m_spins     = 0;
            m_just_left = 0;
            exp_cmd     = 3'b100;
        end else begin
            model_turn();
            m_right_left = 2;
            m_just_left  = 0;
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic do_step(input bit h, input bit l, input bit u, input bit b);
        head    = h;
        left    = l;
        under   = u;
        barrier = b;
        passo   = 1'b1;
        @(posedge clock);
        #1;
        passo = 1'b0;
        model_step(h, l, u, b);
    endtask

    task automatic do_reset();
        passo = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        passo   = 1'b0;
        head    = 1'b0;
        left    = 1'b0;
        under   = 1'b0;
        barrier = 1'b0;
        model_reset();
        #3;
        checks++;
        if ({avancar, girar, remover, fim, erro} !== 5'b00000) begin
            failures++;
            $display("FAIL reset_outputs got=%b want=00000",
                     {avancar, girar, remover, fim, erro});
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_start_fim();
        logic [4:0] want [3];
        want[0] = 5'b10000;
        want[1] = 5'b10000;
        want[2] = 5'b00010;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_step(1'b0, 1'b1, (i != 1), 1'b0);
            checks++;
            if ({avancar, girar, remover, fim, erro} !== want[i]) begin
                failures++;
                $display("FAIL start_fim[%0d] got=%b want=%b", i,
                         {avancar, girar, remover, fim, erro}, want[i]);
            end
        end
        do_step(1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({avancar, girar, remover, fim, erro} !== 5'b00010) begin
            failures++;
            $display("FAIL fim_absorbing got=%b want=00010",
                     {avancar, girar, remover, fim, erro});
        end
    endtask

    task automatic test_left_opening();
        do_reset();
        do_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({avancar, girar, remover} !== 3'b010) begin
            failures++;
            $display("FAIL left_turn got=%b want=010", {avancar, girar, remover});
        end
        @(posedge clock);
        #1;
        checks++;
        if ({avancar, girar, remover} !== 3'b000) begin
            failures++;
            $display("FAIL cmd_one_cycle got=%b want=000", {avancar, girar, remover});
        end
        do_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({avancar, girar, remover} !== 3'b100) begin
            failures++;
            $display("FAIL enter_opening got=%b want=100", {avancar, girar, remover});
        end
    endtask

    task automatic test_right_turn();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i == 0) do_step(1'b1, 1'b1, 1'b0, 1'b0);
            else do_step($urandom_range(1), $urandom_range(1),
                         $urandom_range(1), $urandom_range(1));
            checks++;
            if ({avancar, girar, remover, erro} !== 4'b0100) begin
                failures++;
                $display("FAIL right_turn[%0d] got=%b want=0100", i,
                         {avancar, girar, remover, erro});
            end
        end
        do_step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({avancar, girar, remover} !== 3'b100) begin
            failures++;
            $display("FAIL after_right got=%b want=100", {avancar, girar, remover});
        end
    endtask

    task automatic test_removal();
        int vidas;
        vidas = vidas_detrito(DEB_PESADO);
        do_reset();
        for (int i = 0; i <= vidas; i++) begin
            do_step(1'b1, 1'b1, 1'b0, (i < vidas));
            checks++;
            if ({avancar, girar, remover} !== exp_cmd ||
                exp_cmd !== ((i < vidas) ? 3'b001 : 3'b100)) begin
                failures++;
                $display("FAIL removal[%0d] got=%b want=%b", i,
                         {avancar, girar, remover}, exp_cmd);
            end
        end
    endtask

    task automatic test_removal_timeout();
        do_reset();
        for (int i = 0; i < MAX_REM + 1; i++) begin
            do_step(1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if ({avancar, girar, remover, erro} !==
                ((i < MAX_REM) ? 4'b0010 : 4'b0001)) begin
                failures++;
                $display("FAIL rem_timeout[%0d] got=%b", i,
                         {avancar, girar, remover, erro});
            end
        end
        do_step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({avancar, girar, remover, fim, erro} !== 5'b00001) begin
            failures++;
            $display("FAIL erro_absorbing got=%b want=00001",
                     {avancar, girar, remover, fim, erro});
        end
    endtask

    task automatic test_spin_error();
        do_reset();
        for (int i = 0; i < MAX_GIRO; i++) begin
            do_step((i % 3 == 0), 1'b1, 1'b0, 1'b0);
            checks++;
            if ({avancar, girar, remover, erro} !==
                ((i < MAX_GIRO - 1) ? 4'b0100 : 4'b0001)) begin
                failures++;
                $display("FAIL spin[%0d] got=%b", i, {avancar, girar, remover, erro});
            end
        end
    endtask

    task automatic test_reset_mid_command();
        do_reset();
        do_step(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (girar !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_girar got=%b want=1", girar);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({avancar, girar, remover, fim, erro} !== 5'b00000) begin
            failures++;
            $display("FAIL async_clear got=%b want=00000",
                     {avancar, girar, remover, fim, erro});
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        do_step(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if ({avancar, girar, remover, fim, erro} !== 5'b10000) begin
            failures++;
            $display("FAIL saiu_cleared got=%b want=10000",
                     {avancar, girar, remover, fim, erro});
        end
    endtask

    task automatic test_random();
        int idle;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ((m_fim || m_err) && ($urandom_range(3) == 0)) do_reset();
            do_step($urandom_range(1), $urandom_range(1),
                    ($urandom_range(4) == 0), ($urandom_range(5) == 0));
            checks++;
            if ({avancar, girar, remover, fim, erro} !==
                {exp_cmd, m_fim, m_err}) begin
                failures++;
                $display("FAIL random[%0d] got=%b want=%b", i,
                         {avancar, girar, remover, fim, erro},
                         {exp_cmd, m_fim, m_err});
            end
            idle = $urandom_range(2);
            for (int k = 0; k < idle; k++) begin
                @(posedge clock);
                #1;
                checks++;
                if ({avancar, girar, remover, fim, erro} !==
                    {3'b000, m_fim, m_err}) begin
                    failures++;
                    $display("FAIL random_idle[%0d] got=%b want=%b", i,
                             {avancar, girar, remover, fim, erro},
                             {3'b000, m_fim, m_err});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_fim();
        test_left_opening();
        test_right_turn();
        test_removal();
        test_removal_timeout();
        test_spin_error();
        test_reset_mid_command();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
